// File: rtl/mult_stage_m1_pkg.sv
// mult_stage_m1_pkg: shared widths, product type and overflow-check constants for the multiply stage
package mult_stage_m1_pkg;
  localparam int REG_SIZE = 32;
  localparam int REG_ADDR = 5;
  localparam int PROD_W = 2 * REG_SIZE;
  typedef logic [PROD_W-1:0] prod_t;
  localparam logic [REG_SIZE-1:0] HI_ZERO = '0;
  localparam logic [REG_SIZE-1:0] HI_ONES = '1;
endpackage

// File: rtl/mult_stage_m1_core.sv
// mult_core: combinational W x W -> 2W multiplier with signed/unsigned select
module mult_core
  import mult_stage_m1_pkg::*;
#(
  parameter int W = REG_SIZE
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           is_signed,
  output logic [2*W-1:0] p
);
  logic [2*W-1:0] w_a;
  logic [2*W-1:0] w_b;
  // the low 2W bits of the extended product are exact for both signednesses
  assign w_a = {{W{is_signed & a[W-1]}}, a};
  assign w_b = {{W{is_signed & b[W-1]}}, b};
  assign p = w_a * w_b;
endmodule

// File: rtl/mult_stage_m1.sv
// mult_stage_m1: first multiply stage registering low product word, zero/overflow flags and write control.
// Optional MULT_M1_STATS_EN adds the mult_count accepted-multiply counter.
module mult_stage_m1
  import mult_stage_m1_pkg::*;
#(
  parameter int DATA_W = REG_SIZE,
  parameter int ADDR_W = REG_ADDR
`ifdef MULT_M1_STATS_EN
  ,parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              regwrite_in,
  input  logic [ADDR_W-1:0] wreg_in,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              is_signed,
  output logic              valid_out,
  output logic              regwrite_out,
  output logic [ADDR_W-1:0] dst_reg,
  output logic [DATA_W-1:0] m1result,
  output logic              zero,
  output logic              overflow
`ifdef MULT_M1_STATS_EN
  ,output logic [CNT_W-1:0] mult_count
`endif
);
  logic [2*DATA_W-1:0] w_p;
  logic                w_ovf;
  logic                r_valid;
  logic                r_regwrite;
  logic [ADDR_W-1:0]   r_dst;
  logic [DATA_W-1:0]   r_res;
  logic                r_zero;
  logic                r_ovf;
  mult_core #(.W(DATA_W)) u_core (
    .a(src_a),
    .b(src_b),
    .is_signed(is_signed),
    .p(w_p)
  );
  assign w_ovf = w_p[2*DATA_W-1:DATA_W] != (is_signed ? {DATA_W{w_p[DATA_W-1]}} : {DATA_W{1'b0}});
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_dst      <= '0;
      r_res      <= '0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
    end else if (we) begin
      r_valid    <= valid_in;
      r_regwrite <= regwrite_in & valid_in;
      r_dst      <= wreg_in;
      r_res      <= w_p[DATA_W-1:0];
      r_zero     <= w_p == '0;
      r_ovf      <= w_ovf;
    end
  end
  assign valid_out    = r_valid;
  assign regwrite_out = r_regwrite;
  assign dst_reg      = r_dst;
  assign m1result     = r_res;
  assign zero         = r_zero;
  assign overflow     = r_ovf;
`ifdef MULT_M1_STATS_EN
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (we && valid_in && !flush) r_cnt <= r_cnt + 1'b1;
  end
  assign mult_count = r_cnt;
`endif
endmodule

// File: tb/tb_mult_stage_m1.sv
// tb_mult_stage_m1: directed-vector bench for mult_stage_m1 with hand-computed expectations
module tb_mult_stage_m1;
  logic        clk = 1'b0;
  logic        reset, we, flush, valid_in, regwrite_in, is_signed;
  logic [4:0]  wreg_in;
  logic [31:0] src_a, src_b;
  logic        valid_out, regwrite_out, zero, overflow;
  logic [4:0]  dst_reg;
  logic [31:0] m1result;
  int total = 0;
  int bad = 0;
`ifdef MULT_M1_STATS_EN
  logic [2:0] mult_count;
  mult_stage_m1 #(.CNT_W(3)) dut (
`else
  mult_stage_m1 dut (
`endif
    .clk(clk), .reset(reset), .we(we), .flush(flush), .valid_in(valid_in),
    .regwrite_in(regwrite_in), .wreg_in(wreg_in), .src_a(src_a), .src_b(src_b),
    .is_signed(is_signed), .valid_out(valid_out), .regwrite_out(regwrite_out),
    .dst_reg(dst_reg), .m1result(m1result), .zero(zero), .overflow(overflow)
`ifdef MULT_M1_STATS_EN
    ,.mult_count(mult_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic rw, input logic [4:0] wr,
                       input logic [31:0] a, input logic [31:0] b, input logic s);
    valid_in = v; regwrite_in = rw; wreg_in = wr; src_a = a; src_b = b; is_signed = s;
  endtask
  initial begin
    reset = 1'b1; we = 1'b1; flush = 1'b0;
    drive(1'b1, 1'b1, 5'd9, 32'd3, 32'd3, 1'b0);
    step();
    chk("rst_valid", valid_out, 0);
    chk("rst_rw", regwrite_out, 0);
    chk("rst_dst", dst_reg, 0);
    chk("rst_res", m1result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 32'd7, 32'd6, 1'b0);
    step();
    chk("u7x6_res", m1result, 42);
    chk("u7x6_zero", zero, 0);
    chk("u7x6_ovf", overflow, 0);
    chk("u7x6_valid", valid_out, 1);
    chk("u7x6_rw", regwrite_out, 1);
    chk("u7x6_dst", dst_reg, 3);
    drive(1'b1, 1'b1, 5'd4, 32'h8000_0000, 32'h8000_0000, 1'b1);
    step();
    chk("smin_res", m1result, 0);
    chk("smin_zero", zero, 0);
    chk("smin_ovf", overflow, 1);
    drive(1'b1, 1'b1, 5'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    step();
    chk("sm1_res", m1result, 1);
    chk("sm1_ovf", overflow, 0);
    drive(1'b1, 1'b1, 5'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    step();
    chk("umax_res", m1result, 1);
    chk("umax_ovf", overflow, 1);
    drive(1'b1, 1'b1, 5'd5, 32'd0, 32'h1234, 1'b0);
    step();
    chk("zero_flag", zero, 1);
    chk("zero_res", m1result, 0);
    we = 1'b0;
    drive(1'b1, 1'b1, 5'd6, 32'd5, 32'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_zero", zero, 1);
      chk("stall_res", m1result, 0);
      chk("stall_dst", dst_reg, 5);
    end
    we = 1'b1;
    step();
    chk("resume_res", m1result, 25);
    chk("resume_zero", zero, 0);
    flush = 1'b1;
    drive(1'b1, 1'b1, 5'd9, 32'd3, 32'd3, 1'b0);
    step();
    chk("flush_valid", valid_out, 0);
    chk("flush_rw", regwrite_out, 0);
    chk("flush_dst", dst_reg, 6);
    chk("flush_res", m1result, 25);
    flush = 1'b0;
    drive(1'b0, 1'b1, 5'd7, 32'd2, 32'd2, 1'b0);
    step();
    chk("bub_valid", valid_out, 0);
    chk("bub_rw", regwrite_out, 0);
    chk("bub_res", m1result, 4);
    chk("bub_dst", dst_reg, 7);
`ifdef MULT_M1_STATS_EN
    chk("cnt_six", mult_count, 6);
    drive(1'b1, 1'b0, 5'd8, 32'd1, 32'd1, 1'b0);
    step();
    step();
    chk("cnt_wrap", mult_count, 0);
`endif
    drive(1'b1, 1'b1, 5'd10, 32'hFFFF_FFFF, 32'd2, 1'b0);
    step();
    chk("pre_rst_valid", valid_out, 1);
    chk("pre_rst_ovf", overflow, 1);
    reset = 1'b1; we = 1'b0;
    step();
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_rw", regwrite_out, 0);
    chk("mid_rst_dst", dst_reg, 0);
    chk("mid_rst_res", m1result, 0);
    chk("mid_rst_ovf", overflow, 0);
`ifdef MULT_M1_STATS_EN
    chk("mid_rst_cnt", mult_count, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
